// File: rtl/branch_cond_pipe.sv
// Two-stage pipelined branch-condition evaluator (EQ/NE and signed compare-with-zero) with valid/ready and flush.
// Optional statistics counters are compiled in when BRANCH_COND_STATS_EN is defined.
module branch_cond_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       InMode,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             OutTaken,
    output logic             OutZero,
    output logic             OutErr,
    output logic [TAG_W-1:0] OutTag
`ifdef BRANCH_COND_STATS_EN
    ,
    input  logic             StatClr,
    output logic [CNT_W-1:0] StatEvals,
    output logic [CNT_W-1:0] StatTaken
`endif
);

    typedef enum logic [2:0] {
        MODE_EQ   = 3'b000,
        MODE_NE   = 3'b001,
        MODE_LEZ  = 3'b010,
        MODE_GTZ  = 3'b011,
        MODE_LTZ  = 3'b100,
        MODE_GEZ  = 3'b101,
        MODE_ZERO = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

    logic             r_s1Valid;
    mode_t            r_s1Mode;
    logic [TAG_W-1:0] r_s1Tag;
    logic             r_s1Eq;
    logic             r_s1Zero;
    logic             r_s1Sign;

    logic             r_s2Valid;
    logic             r_outTaken;
    logic             r_outZero;
    logic             r_outErr;
    logic [TAG_W-1:0] r_outTag;

    logic             w_s2Advance;
    logic             w_inFire;
    logic             w_taken;
    logic             w_err;

    assign w_s2Advance = !r_s2Valid || OutReady;
    assign InReady     = (!r_s1Valid || w_s2Advance) && !Flush;
    assign w_inFire    = InValid && InReady;

    // Stage 1 holds only the precomputed flags, so the wide compares happen once, up front.
    always_comb begin
        w_taken = 1'b0;
        w_err   = 1'b0;
        case (r_s1Mode)
            MODE_EQ:   w_taken = r_s1Eq;
            MODE_NE:   w_taken = !r_s1Eq;
            MODE_LEZ:  w_taken = r_s1Sign || r_s1Zero;
            MODE_GTZ:  w_taken = !r_s1Sign && !r_s1Zero;
            MODE_LTZ:  w_taken = r_s1Sign;
            MODE_GEZ:  w_taken = !r_s1Sign;
            MODE_ZERO: w_taken = r_s1Zero;
            default:   w_err   = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1Mode   <= MODE_EQ;
            r_s1Tag    <= '0;
            r_s1Eq     <= 1'b0;
            r_s1Zero   <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s2Valid  <= 1'b0;
            r_outTaken <= 1'b0;
            r_outZero  <= 1'b0;
            r_outErr   <= 1'b0;
            r_outTag   <= '0;
        end else if (Flush) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
        end else begin
            if (w_s2Advance) begin
                r_s2Valid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_outTaken <= w_taken;
                    r_outZero  <= r_s1Zero;
                    r_outErr   <= w_err;
                    r_outTag   <= r_s1Tag;
                end
            end
            if (w_inFire) begin
                r_s1Valid <= 1'b1;
                r_s1Mode  <= mode_t'(InMode);
                r_s1Tag   <= InTag;
                r_s1Eq    <= (InA == InB);
                r_s1Zero  <= (InA == '0);
                r_s1Sign  <= InA[WIDTH-1];
            end else if (w_s2Advance) begin
                r_s1Valid <= 1'b0;
            end
        end
    end

    assign OutValid = r_s2Valid;
    assign OutTaken = r_outTaken;
    assign OutZero  = r_outZero;
    assign OutErr   = r_outErr;
    assign OutTag   = r_outTag;

`ifdef BRANCH_COND_STATS_EN
    logic             w_outFire;
    logic [CNT_W-1:0] r_statEvals;
    logic [CNT_W-1:0] r_statTaken;

    // A result discarded by a flush in the same cycle is not counted as consumed.
    assign w_outFire = r_s2Valid && OutReady && !Flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_statEvals <= '0;
            r_statTaken <= '0;
        end else if (StatClr) begin
            r_statEvals <= '0;
            r_statTaken <= '0;
        end else if (w_outFire) begin
            if (r_statEvals != '1) r_statEvals <= r_statEvals + 1'b1;
            if (r_outTaken && (r_statTaken != '1)) r_statTaken <= r_statTaken + 1'b1;
        end
    end

    assign StatEvals = r_statEvals;
    assign StatTaken = r_statTaken;
`else
    if (CNT_W < 1) begin : g_cntWidthUnused
    end
`endif

endmodule
